// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and defaults for the SPI transaction sequencer
package spi_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LEN_W_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CS_SETUP  = 3'd1,
    LOAD      = 3'd2,
    ISSUE     = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5,
    CAPTURE   = 3'd6,
    CS_HOLD   = 3'd7
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty flags
module sync_fifo
  import spi_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Gate requests with the current flags, then advance pointers and occupancy.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    full_d   = (count_d == (PW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Pointer, occupancy and flag registers; contents are abandoned on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - multi-byte SPI transaction sequencer owning chip select
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             cs_n,
  output logic             byte_wr,
  output logic [7:0]       byte_tx,
  input  logic             byte_done,
  input  logic [7:0]       byte_rx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             cs_n_q, cs_n_d;
  logic             byte_wr_q, byte_wr_d;
  logic [7:0]       byte_tx_q, byte_tx_d;
  logic             busy_q, busy_d;

  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]       tx_head;
  logic [CW-1:0]    tx_count, rx_count;
  logic             tx_pop, rx_push;
  logic             unused_cnt;

  assign unused_cnt = ^{tx_count, rx_count};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (byte_rx),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign tx_pop  = (state_q == ISSUE);
  assign rx_push = (state_q == CAPTURE);

  // Next-state, byte counter and output decode; CS follows the next state so it is registered.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    byte_tx_d   = byte_tx_q;
    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d     = CS_SETUP;
          remaining_d = len;
        end
      end
      CS_SETUP:  state_d = LOAD;
      LOAD: begin
        // Reserve an RX slot before issuing so the capture can never overflow.
        if (!tx_empty && !rx_full) state_d = ISSUE;
      end
      ISSUE: begin
        byte_tx_d = tx_head;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK:  if (!byte_done) state_d = WAIT_DONE;
      WAIT_DONE: if (byte_done) state_d = CAPTURE;
      CAPTURE: begin
        remaining_d = remaining_q - LEN_W'(1);
        state_d     = (remaining_q == LEN_W'(1)) ? CS_HOLD : LOAD;
      end
      CS_HOLD:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    byte_wr_d = (state_q == ISSUE);
    cs_n_d    = (state_d == IDLE) || (state_d == CS_SETUP);
    busy_d    = (state_d != IDLE);
  end

  // FSM and registered outputs; reset drops CS immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cs_n_q      <= 1'b1;
      byte_wr_q   <= 1'b0;
      byte_tx_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cs_n_q      <= cs_n_d;
      byte_wr_q   <= byte_wr_d;
      byte_tx_q   <= byte_tx_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign busy     = busy_q;
  assign cs_n     = cs_n_q;
  assign byte_wr  = byte_wr_q;
  assign byte_tx  = byte_tx_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
  import spi_ctrl_pkg::*;

  localparam int DEPTH = 2;
  localparam int LW    = LEN_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    tx_data = 8'h00;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          busy, cs_n, byte_wr;
  logic [7:0]    byte_tx;
  logic          byte_done = 1'b1;
  logic [7:0]    byte_rx = 8'h00;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .busy      (busy),
    .cs_n      (cs_n),
    .byte_wr   (byte_wr),
    .byte_tx   (byte_tx),
    .byte_done (byte_done),
    .byte_rx   (byte_rx)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: bytes expected on the wire and bytes expected out of RX, in order.
  logic [7:0] tx_model[$];
  logic [7:0] rx_model[$];
  logic [7:0] mask = 8'h00;
  bit         eng_slow = 1'b0;
  bit         drain_en = 1'b0;
  bit         force_ready = 1'b0;
  int         strobes = 0;
  int         cs_falls = 0;
  logic       prev_cs = 1'b1;
  logic       prev_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: strobe width, CS while strobing, strobe and CS-fall counts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_cs && !cs_n) cs_falls++;
      if (byte_wr) begin
        check("wr_one_cycle", prev_wr, 0);
        check("wr_cs_low", cs_n, 0);
        strobes++;
      end
    end
    prev_cs = cs_n;
    prev_wr = byte_wr;
  end

  // Byte engine: no reset, random latencies, returns the sent byte XOR mask.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (byte_wr === 1'b1) begin
        b = byte_tx;
        if (tx_model.size() == 0) check("tx_unexpected", 1, 0);
        else check("byte_tx", b, tx_model.pop_front());
        repeat ($urandom_range(0, 2)) @(negedge clk);
        byte_done = 1'b0;
        repeat (eng_slow ? 12 : $urandom_range(1, 4)) @(negedge clk);
        byte_rx = b ^ mask;
        byte_done = 1'b1;
        rx_model.push_back(b ^ mask);
      end
    end
  end

  // RX consumer: checks each head byte against the model before popping it.
  initial begin
    forever begin
      @(negedge clk);
      if (drain_en && rx_valid === 1'b1) begin
        if (rx_model.size() == 0) check("rx_unexpected", 1, 0);
        else check("rx_data", rx_data, rx_model.pop_front());
        rx_ready = 1'b1;
      end else begin
        rx_ready = force_ready;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_tx(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (tx_ready === 1'b1) begin
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_model.push_back(d);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("push_tx_timeout", ok, 1);
  endtask

  task automatic start_xfer(input int n);
    start = 1'b1;
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    check({tag, "_idle"}, ok, 1);
    check({tag, "_cs_high"}, cs_n, 1);
  endtask

  task automatic drain(input string tag);
    bit ok;
    drain_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rx_model.size() == 0 && rx_valid === 1'b0) ok = 1'b1;
    end
    drain_en = 1'b0;
    check({tag, "_drained"}, ok, 1);
  endtask

  initial begin
    int base, base_cs;
    logic [7:0] d0, d1, d2, d3;
    bit ok;

    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_byte_wr", byte_wr, 0);
    check("rst_byte_tx", byte_tx, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte with loopback and start-to-strobe timing.
    mask = 8'h00;
    push_tx(8'hA5);
    base = strobes; base_cs = cs_falls;
    start_xfer(1);
    check("t1_cs_n_after_n", cs_n, 1);
    check("t1_busy", busy, 1);
    @(negedge clk); check("t1_cs_n_after_n1", cs_n, 0);
    @(negedge clk); check("t1_wr_after_n2", byte_wr, 0);
    @(negedge clk); check("t1_wr_after_n3", byte_wr, 1);
    wait_idle("t1");
    check("t1_strobes", strobes - base, 1);
    check("t1_cs_falls", cs_falls - base_cs, 1);
    check("t1_rx_valid", rx_valid, 1);
    drain("t1");

    // Three-byte burst with CS held low throughout.
    mask = 8'($urandom);
    push_tx(8'h01);
    push_tx(8'h02);
    check("t2_tx_full", tx_ready, 0);
    base = strobes; base_cs = cs_falls;
    drain_en = 1'b1;
    start_xfer(3);
    push_tx(8'h03);
    wait_idle("t2");
    check("t2_strobes", strobes - base, 3);
    check("t2_cs_falls", cs_falls - base_cs, 1);
    drain("t2");

    // TX starvation: stall in LOAD with CS low until the second byte arrives.
    mask = 8'($urandom);
    push_tx(8'h11);
    base = strobes; base_cs = cs_falls;
    drain_en = 1'b1;
    start_xfer(2);
    repeat (20) @(negedge clk);
    check("t3_stall_busy", busy, 1);
    check("t3_stall_cs", cs_n, 0);
    check("t3_stall_strobes", strobes - base, 1);
    push_tx(8'h22);
    wait_idle("t3");
    check("t3_strobes", strobes - base, 2);
    check("t3_cs_falls", cs_falls - base_cs, 1);
    drain("t3");

    // RX backpressure: only DEPTH bytes move until the consumer wakes up.
    mask = 8'($urandom);
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
    drain_en = 1'b0;
    push_tx(d0);
    push_tx(d1);
    base = strobes; base_cs = cs_falls;
    start_xfer(4);
    push_tx(d2);
    push_tx(d3);
    repeat (40) @(negedge clk);
    check("t4_stall_strobes", strobes - base, DEPTH);
    check("t4_stall_busy", busy, 1);
    check("t4_stall_cs", cs_n, 0);
    check("t4_rx_valid", rx_valid, 1);
    check("t4_tx_full", tx_ready, 0);
    drain_en = 1'b1;
    wait_idle("t4");
    check("t4_strobes", strobes - base, 4);
    check("t4_cs_falls", cs_falls - base_cs, 1);
    drain("t4");

    // len=0 is ignored; pop at empty and push at full are blocked.
    mask = 8'($urandom);
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    push_tx(d0);
    base = strobes; base_cs = cs_falls;
    start_xfer(0);
    for (int i = 0; i < 5; i++) begin
      check("t5_len0_busy", busy, 0);
      check("t5_len0_cs", cs_n, 1);
      @(negedge clk);
    end
    check("t5_len0_cs_falls", cs_falls - base_cs, 0);
    force_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rx_empty_pop", rx_valid, 0);
    force_ready = 1'b0;
    push_tx(d1);
    check("t5_tx_full", tx_ready, 0);
    drain_en = 1'b1;
    tx_valid = 1'b1;
    tx_data  = d2;
    start_xfer(2);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (tx_ready === 1'b1) begin
        @(negedge clk);
        tx_valid = 1'b0;
        tx_model.push_back(d2);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    check("t5_push_after_full", ok, 1);
    wait_idle("t5a");
    check("t5_strobes", strobes - base, 2);
    check("t5_tx_retained", tx_ready, 1);
    base = strobes;
    start_xfer(1);
    wait_idle("t5b");
    check("t5_retained_strobe", strobes - base, 1);
    drain("t5");

    // Reset while the engine is mid-byte.
    mask = 8'($urandom);
    eng_slow = 1'b1;
    push_tx(8'($urandom));
    push_tx(8'($urandom));
    base = strobes;
    start_xfer(1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (byte_done === 1'b0) ok = 1'b1;
    end
    check("t6_engine_ack", ok, 1);
    @(negedge clk);
    check("t6_in_wait_cs", cs_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cs_n", cs_n, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wr", byte_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rx_empty", rx_valid, 0);
    check("t6_tx_empty", tx_ready, 1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (byte_done === 1'b1) ok = 1'b1;
    end
    check("t6_engine_done", ok, 1);
    tx_model.delete();
    rx_model.delete();
    eng_slow = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_late_busy", busy, 0);
    check("t6_late_cs", cs_n, 1);
    check("t6_late_rx", rx_valid, 0);
    check("t6_late_strobes", strobes - base, 1);
    mask = 8'($urandom);
    push_tx(8'($urandom));
    base = strobes;
    drain_en = 1'b1;
    start_xfer(1);
    wait_idle("t6");
    check("t6_post_strobes", strobes - base, 1);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Transaction sequencer that sits directly upstream of the SPI byte engine and owns chip select. It accepts a start command with a byte count and buffers outgoing bytes in a TX FIFO. It feeds the bytes one at a time into the engine's write/done handshake and collects each received byte into an RX FIFO. Chip select stays asserted for the whole multi-byte transaction.

## Interface
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `LEN_W`, 8: width of the byte-count field.

- `clk`  in  1: single clock; every register is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a transaction; sampled only in IDLE.
- `len`  in  LEN_W: number of bytes in the transaction; sampled with `start`.
- `tx_valid` / `tx_ready` / `tx_data[7:0]`: TX byte stream into the TX FIFO. A byte is pushed when `tx_valid && tx_ready`. `tx_ready` equals "TX FIFO not full".
- `rx_valid` / `rx_ready` / `rx_data[7:0]`: RX byte stream out of the RX FIFO. A byte is popped when `rx_valid && rx_ready`. `rx_valid` equals "RX FIFO not empty".
- `busy`  out  1: high in every state except IDLE.
- `cs_n`  out  1: chip select, active low; registered.
- `byte_wr`  out  1: one-cycle write strobe to the byte engine; registered.
- `byte_tx`  out  8: byte for the engine; valid while `byte_wr` is high.
- `byte_done`  in  1: engine idle flag; high when the engine is idle.
- `byte_rx`  in  8: engine shift register; valid when `byte_done` returns high.

## Operation
- Reset values: `cs_n`=1, `byte_wr`=0, `byte_tx`=0, `busy`=0, `rx_valid`=0, `tx_ready`=1. Both FIFOs empty; byte counter 0; state IDLE.
- States and transitions:
  - IDLE: `start && len!=0` → CS_SETUP, loading `remaining`=`len`. `start` with `len==0` is ignored: no CS activity, stays IDLE.
  - CS_SETUP: `cs_n` goes low; always → LOAD after 1 cycle.
  - LOAD: TX FIFO non-empty and RX FIFO not full → ISSUE. Otherwise stall here with `cs_n` held low, indefinitely.
  - ISSUE: pop the TX FIFO, assert `byte_wr`=1 with `byte_tx`=head byte for exactly one cycle → WAIT_ACK.
  - WAIT_ACK: wait for `byte_done`=0, meaning the engine has taken the byte → WAIT_DONE.
  - WAIT_DONE: wait for `byte_done`=1 → CAPTURE.
  - CAPTURE: push `byte_rx` into the RX FIFO and decrement `remaining`. If the result is 0 → CS_HOLD, else → LOAD.
  - CS_HOLD: `cs_n` stays low for this cycle → IDLE; `cs_n` returns high on entry to IDLE.
- No assumption on engine byte duration; WAIT_ACK and WAIT_DONE have no timeout.
- The TX FIFO accepts pushes in any state, including IDLE. Software may preload a transaction's bytes before `start`.
- An RX push never overflows, because LOAD reserves space before ISSUE.
- A push and a pop in the same cycle on one FIFO are both honoured; the occupancy count is unchanged.
  - A push into a full FIFO is blocked by its ready signal.
  - A pop from an empty FIFO is blocked by its valid signal.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; the occupancy count is one bit wider.
- `remaining` is LEN_W bits and decrements only in CAPTURE; it cannot underflow.
- Reset mid-transaction: all state returns to its reset values at once, `cs_n` rises asynchronously, and FIFO contents are discarded. The byte engine has no reset and may finish its byte; the controller ignores `byte_done` while in IDLE.

## Timing
- From `start` sampled in IDLE at edge N: `cs_n`=0 after edge N+1, and the earliest `byte_wr` is high after edge N+3, if TX data is present.
- From `byte_done` rising, seen at edge M: RX push at edge M+1, and the next `byte_wr` at edge M+3 at the earliest. The inter-byte gap is therefore 3 cycles plus the engine time.
- The last CAPTURE at edge K leads to `cs_n`=1 after edge K+2.
- `tx_ready` and `rx_valid` are registered flags with one-cycle update latency. `rx_data` comes from the FIFO head and is stable while `rx_valid` is high and no pop occurs.

## Structure
- Package `spi_ctrl_pkg`:
  - state enum: IDLE, CS_SETUP, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, CAPTURE, CS_HOLD.
  - default constants `FIFO_DEPTH_DEF`=4 and `LEN_W_DEF`=8.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count): instantiated twice, once for TX and once for RX.
- The FSM, the `remaining` counter and the CS/strobe registers live in the top module.

## Test plan
- Single byte: preload TX 0xA5, `len`=1, engine model loops MOSI to MISO → one `byte_wr` with `byte_tx`=0xA5; RX gets 0xA5; `cs_n` low across exactly one byte; `busy` falls after CS_HOLD.
- Burst: `len`=3 with 0x01, 0x02, 0x03 preloaded → three strobes in order; `cs_n` stays low continuously between bytes; RX reads 01, 02, 03.
- TX starvation: `len`=2 with only 0x11 preloaded, 0x22 pushed 20 cycles later → stall in LOAD with `cs_n` low; second strobe sends 0x22.
- RX backpressure with FIFO_DEPTH=2: `len`=4, `rx_ready`=0 → exactly 2 bytes transferred, then stall in LOAD. Raising `rx_ready` completes the remaining 2; no RX byte is lost.
- `len`=0 with `start`, plus a simultaneous TX push and RX pop at full/empty boundaries → no CS activity for `len`=0; the pushed byte is retained and the FIFO count is correct.
- Reset asserted in WAIT_DONE → `cs_n`=1 immediately; after release, `busy`=0, both FIFOs empty, and the engine's late `byte_done` is ignored.
